// File: rtl/sweeper_pkg.sv
// Shared types and limits for the truth-table sweeper and its hold timer.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 6;
  localparam int HOLD_MIN  = 1;
  localparam int HOLD_MAX  = 15;

  // Timer wide enough to hold HOLD_MAX-1.
  localparam int TIMER_W = $clog2(HOLD_MAX + 1);

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that marks the last of HOLD cycles, then reloads itself
// so consecutive vectors are held back-to-back without a gap cycle.
module hold_timer
  import sweeper_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(HOLD - 1);

  logic [TIMER_W-1:0] count_reg;
  logic [TIMER_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = RELOAD;
    end else if (run) begin
      count_next = (count_reg == '0) ? RELOAD : count_reg - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= RELOAD;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 2**WIDTH input vectors (binary or Gray order), holds each HOLD cycles,
// captures the sampled response table and counts mismatches against a golden table.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int HOLD  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  gray,
  input  logic [2**WIDTH-1:0]   expected,
  input  logic                  resp_in,
  output logic [WIDTH-1:0]      vec_out,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   table_out,
  output logic [WIDTH:0]        fail_count,
  output logic [WIDTH-1:0]      first_fail
);

  localparam int VECS = 2**WIDTH;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(VECS - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [WIDTH-1:0]  index_reg;
  logic              gray_reg;
  logic [VECS-1:0]   table_reg;
  logic [WIDTH:0]    fail_reg;
  logic [WIDTH-1:0]  first_reg;

  logic accept;
  logic sample;
  logic expire;
  logic mismatch;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .run    (state_reg == DRIVE),
    .expire (expire)
  );

  assign accept   = (state_reg == IDLE) && start;
  // Abort wins over a sample landing in the same cycle.
  assign sample   = (state_reg == DRIVE) && expire && !abort;
  assign vec_out  = gray_reg ? (index_reg ^ (index_reg >> 1)) : index_reg;
  assign mismatch = (resp_in != expected[vec_out]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (expire && (index_reg == LAST)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == DRIVE);
    done = (state_reg == DONE);
  end

  // The index parks on the last vector so vec_out keeps driving it after the sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index_reg <= '0;
      gray_reg  <= 1'b0;
      table_reg <= '0;
      fail_reg  <= '0;
      first_reg <= '0;
    end else if (accept) begin
      index_reg <= '0;
      gray_reg  <= gray;
      table_reg <= '0;
      fail_reg  <= '0;
      first_reg <= '0;
    end else if (sample) begin
      table_reg[vec_out] <= resp_in;
      if (index_reg != LAST) begin
        index_reg <= index_reg + 1'b1;
      end
      if (mismatch) begin
        fail_reg <= fail_reg + 1'b1;
        if (fail_reg == '0) begin
          first_reg <= vec_out;
        end
      end
    end
  end

  assign table_out  = table_reg;
  assign fail_count = fail_reg;
  assign first_fail = first_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: vector table of whole sweeps plus hand-written abort,
// reset and held-start sequences, all checked against a sweep-order model.
module tb_truth_table_sweeper;

  localparam int W   = 3;
  localparam int H   = 2;
  localparam int N   = 1 << W;
  localparam int LAT = N * H + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          gray  = 1'b0;
  logic [N-1:0]  expected = '0;
  logic [N-1:0]  resp_tbl = '0;
  logic          resp_in;
  logic [W-1:0]  vec_out;
  logic          busy;
  logic          done;
  logic [N-1:0]  table_out;
  logic [W:0]    fail_count;
  logic [W-1:0]  first_fail;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [N-1:0] resp;
    logic [N-1:0] gold;
    logic         g;
    logic [N-1:0] t_table;
    int           t_fail;
    int           t_first;
  } rec_t;

  rec_t recs[16];

  truth_table_sweeper #(
    .WIDTH (W),
    .HOLD  (H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .gray       (gray),
    .expected   (expected),
    .resp_in    (resp_in),
    .vec_out    (vec_out),
    .busy       (busy),
    .done       (done),
    .table_out  (table_out),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  always #5 clock = ~clock;

  // Emulated DUT under test: a pure lookup of the applied vector.
  assign resp_in = resp_tbl[vec_out];

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] vec_at(input int i, input logic g);
    logic [W-1:0] b;
    b = W'(i);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  function automatic int model_first(input logic [N-1:0] r, input logic [N-1:0] e,
                                     input logic g);
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] v;
      v = vec_at(i, g);
      if (r[v] != e[v]) return int'(v);
    end
    return 0;
  endfunction

  // Called at a negedge with the sweeper idle; returns at a negedge, idle again.
  task automatic run_sweep(input rec_t r, input int id);
    resp_tbl = r.resp;
    expected = r.gold;
    gray     = r.g;
    start    = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k < LAT) begin
        check("busy_in_sweep", busy, 1);
        check("done_early", done, 0);
        check("vec_order", vec_out, vec_at((k - 1) / H, r.g));
      end else begin
        check("done_latency", done, 1);
        check("busy_in_done", busy, 0);
        check("table_out", table_out, r.t_table);
        check("fail_count", fail_count, r.t_fail);
        if (r.t_fail != 0) check("first_fail", first_fail, r.t_first);
      end
    end
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("vec_held_idle", vec_out, vec_at(N - 1, r.g));
    $display("sweep %0d gray=%0d table=%h errs=%0d first=%0d", id, r.g, table_out,
             fail_count, first_fail);
  endtask

  initial begin
    recs[0] = '{8'h5A, 8'h5A, 1'b0, 8'h5A, 0, 0};
    recs[1] = '{8'h5A, 8'h5B, 1'b0, 8'h5A, 1, 0};
    recs[2] = '{8'h5A, 8'h5A, 1'b1, 8'h5A, 0, 0};
    recs[3] = '{8'h5A, 8'h0A, 1'b0, 8'h5A, 2, 4};
    recs[4] = '{8'h5A, 8'h0A, 1'b1, 8'h5A, 2, 6};
    recs[5] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8, 0};
    for (int i = 6; i < 16; i++) begin
      logic [N-1:0] r;
      logic [N-1:0] m;
      logic         g;
      r = N'($urandom_range(0, 255));
      m = N'($urandom_range(0, 255) & $urandom_range(0, 255));
      g = 1'($urandom_range(0, 1));
      recs[i] = '{r, r ^ m, g, r, $countones(m), model_first(r, r ^ m, g)};
    end

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec", vec_out, 0);
    check("rst_table", table_out, 0);
    check("rst_fail", fail_count, 0);
    check("rst_first", first_fail, 0);

    // Start honoured on the first edge after release
    reset = 1'b1;
    for (int i = 0; i < 16; i++) run_sweep(recs[i], i);

    // Abort on the sample cycle of the 4th vector
    @(negedge clock);
    resp_tbl = 8'hFF;
    expected = 8'hF0;
    gray     = 1'b0;
    start    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("abort_vec_before", vec_out, 3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_table", table_out, 8'h07);
    check("abort_fail", fail_count, 3);
    check("abort_first", first_fail, 0);
    check("abort_vec_held", vec_out, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("abort_no_done", done, 0);
      check("abort_stays_idle", busy, 0);
    end
    $display("abort sweep table=%h errs=%0d", table_out, fail_count);

    // Abort in IDLE does not block a start
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("idle_abort_ignored", busy, 1);
    @(negedge clock);
    abort = 1'b0;
    check("drive_abort_exit", busy, 0);
    $display("idle abort busy=%0d", busy);

    // Reset mid-sweep
    @(negedge clock);
    resp_tbl = 8'hFF;
    expected = 8'h00;
    gray     = 1'b1;
    start    = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("pre_reset_table", table_out, 8'h03);
    check("pre_reset_fail", fail_count, 2);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_vec", vec_out, 0);
    check("mid_rst_table", table_out, 0);
    check("mid_rst_fail", fail_count, 0);
    check("mid_rst_first", first_fail, 0);
    @(negedge clock);
    check("rst_no_done", done, 0);
    reset = 1'b1;
    run_sweep(recs[1], 100);

    // Start held high: back-to-back sweeps with one IDLE cycle between
    resp_tbl = 8'h5A;
    expected = 8'h5A;
    gray     = 1'b0;
    start    = 1'b1;
    for (int k = 1; k <= 2 * (LAT + 1); k++) begin
      int p;
      @(negedge clock);
      p = (k - 1) % (LAT + 1);
      if (p < N * H) begin
        check("held_busy", busy, 1);
        check("held_vec", vec_out, vec_at(p / H, 1'b0));
      end else if (p == N * H) begin
        check("held_done", done, 1);
        check("held_table", table_out, 8'h5A);
      end else begin
        check("held_idle_busy", busy, 0);
        check("held_idle_done", done, 0);
      end
      if (k == 2 * (LAT + 1)) start = 1'b0;
    end
    @(negedge clock);
    check("held_released", busy, 0);
    $display("held start two sweeps table=%h", table_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving the number of DUT inputs swept (legal 1..6).
REQ-002 SHALL have parameter HOLD, default 2, giving the cycles each vector is held before its response is sampled (legal 1..15).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-007 SHALL have port gray  input  1  ordering select: 0 = binary, 1 = Gray; sampled with start.
REQ-008 SHALL have port expected  input  2**WIDTH  golden truth table; bit v is the expected response to vector v.
REQ-009 SHALL have port resp_in  input  1  DUT output under test.
REQ-010 SHALL have port vec_out  output  WIDTH  stimulus vector driven to the DUT.
REQ-011 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a sweep completes normally.
REQ-013 SHALL have port table_out  output  2**WIDTH  captured table; bit v is the sampled response to vector v.
REQ-014 SHALL have port fail_count  output  WIDTH+1  number of vectors where the response differs from expected.
REQ-015 SHALL have port first_fail  output  WIDTH  vector value of the first mismatch; valid only when fail_count != 0.

Function
REQ-016 SHALL implement the states IDLE, DRIVE and DONE.
REQ-017 SHALL, in IDLE with start=1, clear table_out, fail_count and first_fail, latch gray, set the index to 0 and enter DRIVE.
REQ-018 SHALL drive vec_out as the index in binary mode and as index^(index>>1) in Gray mode.
REQ-019 SHALL, in DRIVE, hold each vector for exactly HOLD cycles and sample resp_in on the last of those cycles.
REQ-020 SHALL, on sampling, write table_out[vec_out]=resp_in; on mismatch with expected[vec_out] it increments fail_count and loads first_fail if fail_count was 0.
REQ-021 SHALL, after sampling index 2**WIDTH-1, enter DONE, which lasts 1 cycle with done=1 and then returns to IDLE.
REQ-022 SHALL give a total latency of 2**WIDTH*HOLD+1 cycles from the start edge to done high.
REQ-023 SHALL assert busy in DRIVE only; busy=0 in IDLE and DONE.
REQ-024 SHALL ignore start when it is not in IDLE.
REQ-025 SHALL, on abort in DRIVE, enter IDLE next cycle with no done pulse and no sample taken that cycle; table_out, fail_count and first_fail keep their partial values.
REQ-026 SHALL give abort priority over the sample on a simultaneous abort and sample cycle.
REQ-027 SHALL ignore abort in IDLE and DONE.
REQ-028 SHALL let the index wrap only via the DONE exit; it never overflows silently.
REQ-029 SHALL hold vec_out at the last vector while in DONE and IDLE.
REQ-030 SHALL never saturate fail_count, which is sized to reach 2**WIDTH.

Reset
REQ-031 SHALL, on reset low, asynchronously force state IDLE, index 0, vec_out 0, busy 0, done 0, table_out 0, fail_count 0 and first_fail 0.
REQ-032 SHALL treat reset mid-sweep as an abort that also clears all results; no done pulse is produced.
REQ-033 SHALL have the reset release take effect synchronously; start is honoured on the first clock edge after release.

Structure
REQ-034 SHALL place the state enum (IDLE/DRIVE/DONE) and the WIDTH/HOLD legal limits in the shared package sweeper_pkg.
REQ-035 SHALL use one sub-module, hold_timer: a loadable down-counter that asserts its expire output on the last of HOLD cycles.
REQ-036 SHALL perform the Gray conversion as inline combinational logic, not as a separate module.

Verification
REQ-037 SHALL cover: WIDTH=3, HOLD=2, gray=0, DUT resp=vec[2]^vec[0], expected=8'b01011010 -> done 17 cycles after start, table_out=8'b01011010, fail_count=0.
REQ-038 SHALL cover: the same setup with expected=8'b01011011 -> fail_count=1, first_fail=3'd0.
REQ-039 SHALL cover: gray=1, WIDTH=3 -> vec_out sequence 0,1,3,2,6,7,5,4, with each value held 2 cycles and table_out identical to the binary-mode table.
REQ-040 SHALL cover: abort asserted during the 4th vector -> busy falls next cycle, no done pulse, table_out bits 3..7 remain 0.
REQ-041 SHALL cover: reset pulsed low mid-sweep -> all outputs 0 immediately; a subsequent start runs a full 17-cycle sweep.
REQ-042 SHALL cover: start held high continuously -> sweeps run back-to-back, each preceded by one IDLE cycle, with no start accepted during DRIVE.
